// File: rtl/rpc_delay_cal_ctrl.sv
// rtl/rpc_delay_cal_ctrl.sv - read-data delay-line calibration sweep controller
//
// Purpose: sweeps all 32 delay taps, samples each tap through a req/ack
// handshake, tracks the longest run of passing taps and finally parks the
// delay line in the centre of that window (or restores the pre-run tap when
// nothing passed). Every tap change is wrapped in a one-cycle enable gate and
// followed by a settle interval.
//
// Optional feature macro: RPC_DLY_CAL_OVERRIDE_EN adds a direct tap override.
//
// Ports:
//   clk_i, rst_ni                  clock, synchronous active-low reset
//   cal_start_i                    calibration request (honoured in IDLE)
//   cal_busy_o / cal_done_o        busy level / one-cycle completion pulse
//   cal_fail_o                     sticky: last run found no passing tap
//   sample_req_o                   request a sample at the current tap
//   sample_ack_i / sample_pass_i   sample result strobe and verdict
//   delay_o / delay_en_o           tap value and enable to the delay line
//   win_lo_o / win_len_o           selected pass window start and length
//   ovr_en_i / ovr_tap_i           (macro only) direct tap load from IDLE
module rpc_delay_cal_ctrl #(
   parameter int unsigned SettleCycles  = 16,
   parameter int unsigned SamplesPerTap = 4,
   parameter logic [4:0]  ResetTap      = 5'd15
) (
   input  logic       clk_i,
   input  logic       rst_ni,
   input  logic       cal_start_i,
   output logic       cal_busy_o,
   output logic       cal_done_o,
   output logic       cal_fail_o,
   output logic       sample_req_o,
   input  logic       sample_ack_i,
   input  logic       sample_pass_i,
   output logic [4:0] delay_o,
   output logic       delay_en_o,
   output logic [4:0] win_lo_o,
   output logic [5:0] win_len_o
`ifdef RPC_DLY_CAL_OVERRIDE_EN
   ,
   input  logic       ovr_en_i,
   input  logic [4:0] ovr_tap_i
`endif
);

   typedef enum logic [2:0] {
      ST_IDLE, ST_GATE, ST_SETTLE, ST_SAMPLE, ST_NEXT, ST_APPLY, ST_DONE
   } state_t;

   // What the current GATE/SETTLE pass is for decides where SETTLE exits.
   typedef enum logic [1:0] {M_SWEEP, M_FINAL, M_OVR} mode_t;

   localparam logic [7:0] SettleLast  = 8'(SettleCycles - 1);
   localparam logic [3:0] SamplesLast = 4'(SamplesPerTap - 1);

   state_t     r_state, w_state_next;
   mode_t      r_mode, w_mode_next;
   logic [4:0] r_tap, r_delay, r_pre_tap, w_gate_tap;
   logic       r_delay_en, r_busy, r_done, r_req, r_fail;
   logic [7:0] r_cnt;
   logic [3:0] r_pass_cnt;
   logic       r_tap_pass;
   logic [4:0] r_run_lo, r_best_lo;
   logic [5:0] r_run_len, r_best_len;
   logic       w_start, w_set_fail;
   logic       w_ovr_en;
   logic [4:0] w_ovr_tap;

`ifdef RPC_DLY_CAL_OVERRIDE_EN
   assign w_ovr_en  = ovr_en_i;
   assign w_ovr_tap = ovr_tap_i;
`else
   assign w_ovr_en  = 1'b0;
   assign w_ovr_tap = 5'd0;
`endif

   // Run bookkeeping: the candidate is the run as it stands after this tap.
   logic [5:0] w_ext_len, w_cand_len;
   logic [4:0] w_ext_lo, w_cand_lo, w_half;
   logic       w_close;
   assign w_ext_len  = r_run_len + 6'd1;
   assign w_ext_lo   = (r_run_len == 6'd0) ? r_tap : r_run_lo;
   assign w_cand_len = r_tap_pass ? w_ext_len : r_run_len;
   assign w_cand_lo  = r_tap_pass ? w_ext_lo : r_run_lo;
   assign w_close    = !r_tap_pass || (r_tap == 5'd31);
   assign w_half     = 5'((r_best_len - 6'd1) >> 1);

   always_ff @(posedge clk_i) begin
      if (!rst_ni) r_state <= ST_IDLE;
      else         r_state <= w_state_next;
   end

   always_comb begin
      w_state_next = r_state;
      w_mode_next  = r_mode;
      w_gate_tap   = r_tap;
      w_start      = 1'b0;
      w_set_fail   = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (w_ovr_en) begin
               w_state_next = ST_GATE;
               w_mode_next  = M_OVR;
               w_gate_tap   = w_ovr_tap;
            end else if (cal_start_i) begin
               w_state_next = ST_GATE;
               w_mode_next  = M_SWEEP;
               w_gate_tap   = 5'd0;
               w_start      = 1'b1;
            end
         end
         ST_GATE: w_state_next = ST_SETTLE;
         ST_SETTLE: begin
            if (r_cnt == SettleLast) begin
               case (r_mode)
                  M_SWEEP: w_state_next = ST_SAMPLE;
                  M_FINAL: w_state_next = ST_DONE;
                  default: w_state_next = ST_IDLE;
               endcase
            end
         end
         ST_SAMPLE: begin
            if (sample_ack_i && (!sample_pass_i || r_pass_cnt == SamplesLast))
               w_state_next = ST_NEXT;
         end
         ST_NEXT: begin
            if (r_tap != 5'd31) begin
               w_state_next = ST_GATE;
               w_gate_tap   = r_tap + 5'd1;
            end else begin
               w_state_next = ST_APPLY;
            end
         end
         ST_APPLY: begin
            w_state_next = ST_GATE;
            w_mode_next  = M_FINAL;
            if (r_best_len != 6'd0) begin
               w_gate_tap = r_best_lo + w_half;
            end else begin
               w_gate_tap = r_pre_tap;
               w_set_fail = 1'b1;
            end
         end
         ST_DONE: w_state_next = ST_IDLE;
         default: w_state_next = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         r_mode     <= M_SWEEP;
         r_tap      <= ResetTap;
         r_delay    <= ResetTap;
         r_pre_tap  <= ResetTap;
         r_delay_en <= 1'b1;
         r_busy     <= 1'b0;
         r_done     <= 1'b0;
         r_req      <= 1'b0;
         r_fail     <= 1'b0;
         r_cnt      <= 8'd0;
         r_pass_cnt <= 4'd0;
         r_tap_pass <= 1'b0;
         r_run_lo   <= 5'd0;
         r_run_len  <= 6'd0;
         r_best_lo  <= 5'd0;
         r_best_len <= 6'd0;
      end else begin
         r_mode <= w_mode_next;
         // Outputs are registered from the next state so they never glitch.
         r_delay_en <= (w_state_next != ST_GATE);
         r_busy     <= (w_state_next != ST_IDLE);
         r_done     <= (w_state_next == ST_DONE);
         r_req      <= (w_state_next == ST_SAMPLE);
         // The tap only moves on the edge that enters GATE, i.e. while the
         // delay line enable is being held low.
         if (w_state_next == ST_GATE) begin
            r_tap   <= w_gate_tap;
            r_delay <= w_gate_tap;
         end
         if (w_start) begin
            r_pre_tap  <= r_delay;
            r_fail     <= 1'b0;
            r_run_lo   <= 5'd0;
            r_run_len  <= 6'd0;
            r_best_lo  <= 5'd0;
            r_best_len <= 6'd0;
         end
         if (w_set_fail) r_fail <= 1'b1;
         if (r_state == ST_SETTLE) r_cnt <= r_cnt + 8'd1;
         else                      r_cnt <= 8'd0;
         if (r_state == ST_SAMPLE) begin
            if (sample_ack_i) begin
               r_pass_cnt <= sample_pass_i ? r_pass_cnt + 4'd1 : 4'd0;
               r_tap_pass <= sample_pass_i;
            end
         end else begin
            r_pass_cnt <= 4'd0;
         end
         if (r_state == ST_NEXT) begin
            if (r_tap_pass) begin
               r_run_lo  <= w_ext_lo;
               r_run_len <= w_ext_len;
            end else begin
               r_run_len <= 6'd0;
            end
            // Strictly longer only, so an equal later window loses the tie.
            if (w_close && (w_cand_len > r_best_len)) begin
               r_best_lo  <= w_cand_lo;
               r_best_len <= w_cand_len;
            end
         end
      end
   end

   assign cal_busy_o   = r_busy;
   assign cal_done_o   = r_done;
   assign cal_fail_o   = r_fail;
   assign sample_req_o = r_req;
   assign delay_o      = r_delay;
   assign delay_en_o   = r_delay_en;
   assign win_lo_o     = r_best_lo;
   assign win_len_o    = r_best_len;

endmodule

// File: doc/rpc_delay_cal_ctrl.md
RPC_DELAY_CAL_CTRL -- requirements
Module: rpc_delay_cal_ctrl

Interface
REQ-001 SHALL have parameter SettleCycles, default 16, cycles waited after each tap change before sampling (range 1..255).
REQ-002 SHALL have parameter SamplesPerTap, default 4, consecutive passing samples required for a tap to count as pass (range 1..15).
REQ-003 SHALL have parameter ResetTap, default 5'd15, delay tap driven out of reset.
REQ-004 SHALL have port clk_i  input  1  single clock; all logic on rising edge.
REQ-005 SHALL have port rst_ni  input  1  reset, synchronous and active-low.
REQ-006 SHALL have port cal_start_i  input  1  calibration request, sampled only in IDLE.
REQ-007 SHALL have port cal_busy_o  output  1  high while state is not IDLE.
REQ-008 SHALL have port cal_done_o  output  1  one-cycle pulse at calibration end.
REQ-009 SHALL have port cal_fail_o  output  1  sticky; no passing tap found in the last run.
REQ-010 SHALL have port sample_req_o / sample_ack_i / sample_pass_i  output/input/input  1/1/1  sample handshake; result valid when sample_ack_i is high.
REQ-011 SHALL have port delay_o  output  5  tap value driven to the delay line delay_i.
REQ-012 SHALL have port delay_en_o  output  1  delay line enable.
REQ-013 SHALL have port win_lo_o / win_len_o  output  5/6  start and length of the selected pass window.

Function
REQ-014 SHALL implement states IDLE, GATE, SETTLE, SAMPLE, NEXT, APPLY, DONE.
REQ-015 IDLE + cal_start_i=1 SHALL go to GATE with tap=0, run and best-window registers cleared, and cal_fail_o cleared.
REQ-016 GATE SHALL hold delay_en_o=0 for exactly one cycle while loading delay_o with the new tap, then go to SETTLE with delay_en_o=1.
REQ-017 Outside GATE, delay_o SHALL change only at the GATE cycle; no other state modifies it (glitch-safe tap change).
REQ-018 SETTLE SHALL count SettleCycles cycles, then go to SAMPLE.
REQ-019 SAMPLE SHALL hold sample_req_o high until sample_ack_i; each acked fail SHALL mark the tap failed and go to NEXT; SamplesPerTap consecutive acked passes SHALL mark it passed and go to NEXT.
REQ-020 NEXT SHALL update windows: a pass extends the current run (starting it if none); a fail closes it; a closed or terminal run strictly longer than the best SHALL replace it (ties keep the earlier window).
REQ-021 NEXT at tap<31 SHALL increment tap and go to GATE; at tap=31 SHALL close the run and go to APPLY (no wrap-around).
REQ-022 APPLY with best length L>0 SHALL select tap win_lo + floor((L-1)/2) through GATE/SETTLE, then go to DONE.
REQ-023 APPLY with L=0 SHALL set cal_fail_o=1 and restore the tap held before the run through GATE/SETTLE, then go to DONE.
REQ-024 DONE SHALL pulse cal_done_o for one cycle and return to IDLE; win_lo_o/win_len_o SHALL hold until the next start.
REQ-025 cal_start_i while busy SHALL be ignored; sample_ack_i outside SAMPLE SHALL be ignored.

Reset
REQ-026 rst_ni=0 at a clock edge SHALL force IDLE, delay_o=ResetTap, delay_en_o=1, cal_busy_o=0, cal_done_o=0, cal_fail_o=0, sample_req_o=0, win_lo_o=0, win_len_o=0, from any state including mid-sweep.

Configuration
REQ-027 With macro RPC_DLY_CAL_OVERRIDE_EN defined, SHALL add inputs ovr_en_i (1) and ovr_tap_i (5); in IDLE, ovr_en_i=1 loads ovr_tap_i through GATE/SETTLE (no done pulse, no window update) and blocks cal_start_i.
REQ-028 Without RPC_DLY_CAL_OVERRIDE_EN, those ports SHALL be absent and the tap SHALL change only via calibration.

Verification
REQ-029 Reset mid-SETTLE at tap 7 -> next cycle: IDLE, delay_o=15, delay_en_o=1, busy=0.
REQ-030 Taps 10..20 pass, others fail, SamplesPerTap=4 -> win_lo=10, win_len=11, final delay_o=15, one done pulse, fail=0.
REQ-031 Pass windows 3..6 and 20..23 (tie) -> win_lo=3, win_len=4, final delay_o=4.
REQ-032 All taps fail, pre-run tap 15 -> cal_fail_o=1, delay_o=15, win_len=0.
REQ-033 Every tap change -> delay_en_o low exactly one cycle; SETTLE lasts 16 cycles before sample_req_o rises; ack delayed 5 cycles -> req held until ack.
REQ-034 With RPC_DLY_CAL_OVERRIDE_EN, ovr_en_i=1, ovr_tap_i=9 in IDLE -> delay_o=9 after one gated cycle, no cal_done_o pulse.
